sysx_slave_v1: RTL
==================

Name: sysx_slave_v1

Overview:
- Target-side endpoint of the sysX v1 parallel bus, answering the sysX master.
- Recognises its chip-select code and tracks the bus frame: Load, four data bytes LSB-first, Store.
- Deserialises each MOSI word into a receive holding register and serialises a locally supplied word onto MISO.
- Drives the shared bus interrupt line. Sits on peripheral boards, clocked by the peripheral's own clock; all bus inputs are treated as asynchronous.

Parameters:
- SLAVE_ID, 2'h0: chip-select code this slave answers to. Value 3 is reserved for idle; with 3 the slave never selects.
- SYNC_STAGES, 2: synchroniser depth applied to iBusClock, iBusSelect and iBusMOSI.
- UNDERRUN_FILL, 32'hFFFFFFFF: word shifted out on MISO when no TX word is available at Load.

Ports:
- iClock  in  1  local clock; everything is synchronous to its rising edge.
- iReset  in  1  asynchronous, active-high reset.
- iBusClock  in  1  sysX bus clock; held high while the bus is idle.
- iBusSelect  in  2  sysX chip select; 2'h3 = idle.
- iBusMOSI  in  8  master-to-slave byte lane.
- oBusMISO  out  8  slave-to-master byte lane.
- oBusMISOEnable  out  1  tristate enable for oBusMISO on the shared lane.
- oBusInterrupt  out  1  interrupt request to the master.
- iTxData  in  32  word to send on the next frame.
- iTxValid  in  1  TX write strobe, accepted when oTxReady=1.
- oTxReady  out  1  TX holding register empty.
- oRxData  out  32  last received word.
- oRxValid  out  1  RX holding register full.
- iRxReady  in  1  RX pop, effective when oRxValid=1.
- iIntRequest  in  1  single-cycle pulse requesting a bus interrupt.
- iClearFlags  in  1  clears the sticky status flags.
- oOverrun  out  1  sticky: a received word was dropped.
- oUnderrun  out  1  sticky: UNDERRUN_FILL was sent.

Behaviour:
- Reset: asynchronous, active-high. All registers clear, state IDLE.
  - Outputs during/after reset: oBusMISO=0, oBusMISOEnable=0, oBusInterrupt=0, oTxReady=1, oRxValid=0, oRxData=0, oOverrun=0, oUnderrun=0.
  - Reset mid-frame discards any partial word; the master's frame is simply lost.
- Synchronisation: the three bus inputs pass through SYNC_STAGES flops. Edge detection on the synchronised clock produces one-cycle rise/fall strobes.
  - Selected = synchronised select equals SLAVE_ID.
  - Timing requirement: bus half-period must be at least SYNC_STAGES+3 iClock cycles.
- State machine: IDLE, LOAD, B0, B1, B2, B3, STORE.
  - IDLE -> LOAD when Selected rises.
  - On each rise strobe while Selected: LOAD->B0->B1->B2->B3->STORE->LOAD.
  - Fall strobes never change state. The first event after select is a fall inside LOAD and is ignored.
  - Selected dropping in any state -> IDLE in the same cycle; the partial word is discarded, with no RX push and no flag change.
- LOAD entry:
  - TX holding register full: move it to the shift word and set oTxReady=1 next cycle.
  - TX holding register empty: shift word = UNDERRUN_FILL and set oUnderrun.
  - A host write in the same cycle as an empty-register LOAD entry lands in the holding register for the next frame.
- MISO:
  - oBusMISOEnable = 1 in any non-IDLE state.
  - oBusMISO = shift word bytes [7:0], [15:8], [23:16], [31:24] in B0..B3 respectively; 8'h00 in LOAD and STORE.
  - Registered: valid within SYNC_STAGES+2 cycles of the bus rising edge, hence before the master's falling-edge sample.
- MOSI capture: on the fall strobe in Bn, capture the synchronised MOSI into byte n of the assembly word.
- STORE entry (rise from B3): push the assembly word.
  - If oRxValid=1 and iRxReady=0: drop the word and set oOverrun.
  - Otherwise load oRxData and set oRxValid.
  - Pop and push in the same cycle: the new word wins and oRxValid stays 1.
  - Master receive-mode frames (MOSI=FF) are pushed like any other word.
- TX handshake: the holding register is written when iTxValid && oTxReady; oTxReady = holding register empty.
- Interrupt:
  - An iIntRequest pulse sets oBusInterrupt.
  - It clears on the cycle of the next STORE entry, i.e. the master has serviced one word.
  - A pulse arriving in the same cycle as that STORE entry wins, and the line stays set.
- Flags: oOverrun and oUnderrun are sticky until an iClearFlags pulse. A set and a clear in the same cycle: the set wins.
- Select code 3 or another slave's code: outputs stay quiescent and the bus is ignored.

Test Plan:
- Single word: preload TX 32'hA1B2C3D4; master single transfer with SLAVE_ID=0 and rDirectMOSI=32'h11223344 -> master reads MISO 32'hA1B2C3D4; oRxData=32'h11223344, oRxValid=1; oTxReady=1; no flags set.
- Block of 3 words, TX loaded only twice (words 1, 2) -> master receives word1, word2, 32'hFFFFFFFF; oUnderrun=1; RX pops every word in order and oOverrun stays 0.
- Overrun: two frames with no RX pop in between -> oRxData holds the first word, oOverrun=1. iClearFlags -> oOverrun=0.
- Deselect after B1 (force select to 3) -> state IDLE; oRxValid unchanged and no push; the next full frame is received correctly.
- Assert iReset during B2 -> all outputs at reset values immediately; after release the next frame completes normally.
- Interrupt: pulse iIntRequest -> oBusInterrupt=1 and stays high across idle; it drops at the next STORE. Other IDs: SLAVE_ID=2 with master select 1 -> oBusMISOEnable stays 0 and no RX push. SLAVE_ID=3 never selects.

Source files
------------

// File: rtl/sysx_slave_v1.sv
// sysX v1 bus slave: synchronises the asynchronous bus, tracks Load/B0..B3/Store
// frames, deserialises MOSI into an RX holding register and serialises a TX word on MISO.
module sysx_slave_v1 #(
  parameter logic [1:0]  SLAVE_ID      = 2'h0,
  parameter int          SYNC_STAGES   = 2,
  parameter logic [31:0] UNDERRUN_FILL = 32'hFFFFFFFF
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iBusClock,
  input  logic [1:0]  iBusSelect,
  input  logic [7:0]  iBusMOSI,
  output logic [7:0]  oBusMISO,
  output logic        oBusMISOEnable,
  output logic        oBusInterrupt,
  input  logic [31:0] iTxData,
  input  logic        iTxValid,
  output logic        oTxReady,
  output logic [31:0] oRxData,
  output logic        oRxValid,
  input  logic        iRxReady,
  input  logic        iIntRequest,
  input  logic        iClearFlags,
  output logic        oOverrun,
  output logic        oUnderrun
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_B0    = 3'd2;
  localparam logic [2:0] ST_B1    = 3'd3;
  localparam logic [2:0] ST_B2    = 3'd4;
  localparam logic [2:0] ST_B3    = 3'd5;
  localparam logic [2:0] ST_STORE = 3'd6;

  logic [SYNC_STAGES-1:0] clkSync;
  logic [1:0]             selSync  [SYNC_STAGES];
  logic [7:0]             mosiSync [SYNC_STAGES];
  logic                   clkPrev;
  logic                   selPrev;

  logic        busClk;
  logic [1:0]  busSel;
  logic [7:0]  busMosi;
  logic        busRise;
  logic        busFall;
  logic        selected;
  logic        selRise;

  logic [2:0]  state;
  logic [2:0]  stateNext;
  logic        loadEntry;
  logic        storeEntry;
  logic        txFull;
  logic [31:0] txHold;
  logic        txAccept;
  logic [31:0] shiftWord;
  logic [31:0] asmWord;
  logic        overrunSet;
  logic        underrunSet;
  logic [7:0]  misoNext;

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      // NOTE: synchroniser arrays are reset to the bus idle levels (clock high,
      // select 3) so leaving reset never fabricates a bus edge or a select.
      clkSync <= '1;
      clkPrev <= 1'b1;
      selPrev <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        selSync[i]  <= 2'h3;
        mosiSync[i] <= 8'h00;
      end
    end else begin
      clkSync[0]  <= iBusClock;
      selSync[0]  <= iBusSelect;
      mosiSync[0] <= iBusMOSI;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        clkSync[i]  <= clkSync[i-1];
        selSync[i]  <= selSync[i-1];
        mosiSync[i] <= mosiSync[i-1];
      end
      clkPrev <= busClk;
      selPrev <= selected;
    end
  end

  assign busClk   = clkSync[SYNC_STAGES-1];
  assign busSel   = selSync[SYNC_STAGES-1];
  assign busMosi  = mosiSync[SYNC_STAGES-1];
  assign busRise  = busClk & ~clkPrev;
  assign busFall  = ~busClk & clkPrev;
  assign selected = (SLAVE_ID != 2'h3) && (busSel == SLAVE_ID);
  assign selRise  = selected & ~selPrev;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    stateNext = state;
    if (!selected) begin
      stateNext = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (selRise) stateNext = ST_LOAD;
        ST_LOAD:  if (busRise) stateNext = ST_B0;
        ST_B0:    if (busRise) stateNext = ST_B1;
        ST_B1:    if (busRise) stateNext = ST_B2;
        ST_B2:    if (busRise) stateNext = ST_B3;
        ST_B3:    if (busRise) stateNext = ST_STORE;
        ST_STORE: if (busRise) stateNext = ST_LOAD;
        default:  stateNext = ST_IDLE;
      endcase
    end
  end

  assign loadEntry   = (stateNext == ST_LOAD) && (state != ST_LOAD);
  assign storeEntry  = selected && busRise && (state == ST_B3);
  assign txAccept    = iTxValid && !txFull;
  assign oTxReady    = !txFull;
  assign overrunSet  = storeEntry && oRxValid && !iRxReady;
  assign underrunSet = loadEntry && !txFull;

  always_comb begin
    misoNext = 8'h00;
    case (stateNext)
      ST_B0:   misoNext = shiftWord[7:0];
      ST_B1:   misoNext = shiftWord[15:8];
      ST_B2:   misoNext = shiftWord[23:16];
      ST_B3:   misoNext = shiftWord[31:24];
      default: misoNext = 8'h00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state          <= ST_IDLE;
      txFull         <= 1'b0;
      txHold         <= '0;
      shiftWord      <= '0;
      asmWord        <= '0;
      oRxData        <= '0;
      oRxValid       <= 1'b0;
      oOverrun       <= 1'b0;
      oUnderrun      <= 1'b0;
      oBusInterrupt  <= 1'b0;
      oBusMISO       <= 8'h00;
      oBusMISOEnable <= 1'b0;
    end else begin
      state          <= stateNext;
      oBusMISO       <= misoNext;
      oBusMISOEnable <= (stateNext != ST_IDLE);

      // A full holding register cannot accept a write, so the two never collide.
      if (loadEntry && txFull) begin
        shiftWord <= txHold;
        txFull    <= 1'b0;
      end else begin
        if (loadEntry) shiftWord <= UNDERRUN_FILL;
        if (txAccept) begin
          txHold <= iTxData;
          txFull <= 1'b1;
        end
      end

      if (busFall) begin
        case (state)
          ST_B0:   asmWord[7:0]   <= busMosi;
          ST_B1:   asmWord[15:8]  <= busMosi;
          ST_B2:   asmWord[23:16] <= busMosi;
          ST_B3:   asmWord[31:24] <= busMosi;
          default: ;
        endcase
      end

      if (storeEntry && !overrunSet) begin
        oRxData  <= asmWord;
        oRxValid <= 1'b1;
      end else if (oRxValid && iRxReady) begin
        oRxValid <= 1'b0;
      end

      if (iIntRequest)     oBusInterrupt <= 1'b1;
      else if (storeEntry) oBusInterrupt <= 1'b0;

      if (overrunSet)       oOverrun <= 1'b1;
      else if (iClearFlags) oOverrun <= 1'b0;

      if (underrunSet)      oUnderrun <= 1'b1;
      else if (iClearFlags) oUnderrun <= 1'b0;
    end
  end

endmodule
